// File: rtl/stream_pkg.sv
// Shared stream-fabric definitions.
// Used by both the multiplexor and demultiplexor sides.
package stream_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 2;
  localparam int DEFAULT_DATA_WIDTH    = 8;

  function automatic int channel_count(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/stream_multiplexor_arbiter.sv
// Combinational round-robin arbiter.
// Searches from last_grant+1, wrapping modulo N.
module round_robin_arbiter #(
  parameter  int N  = 4,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_request,
  input  logic [AW-1:0] i_last_grant,
  input  logic          i_enable,
  output logic [N-1:0]  o_grant,
  output logic          o_grant_valid
);

  logic found;
  int   idx;

  // first requester after the previous winner
  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(i_last_grant) + i) % N;
      if (!found && i_request[idx]) begin
        o_grant[idx] = i_enable;
        found        = 1'b1;
      end
    end
    o_grant_valid = found & i_enable;
  end

endmodule

// File: rtl/stream_multiplexor.sv
// N-to-1 round-robin stream multiplexor, registered output.
// Optional packet lock: define STREAM_MULTIPLEXOR_LAST_EN.
module stream_multiplexor
  import stream_pkg::*;
#(
  parameter  int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter  int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  localparam int N             = channel_count(ADDRESS_WIDTH)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N-1:0]            i_valid,
  input  logic [N*DATA_WIDTH-1:0] i_data,
`ifdef STREAM_MULTIPLEXOR_LAST_EN
  input  logic [N-1:0]            i_last,
  output logic                    o_last,
`endif
  output logic [N-1:0]            o_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  input  logic                    i_ready
);

  logic                     o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0]    o_data_q, o_data_d;
  logic [ADDRESS_WIDTH-1:0] o_addr_q, o_addr_d;
  logic [ADDRESS_WIDTH-1:0] last_q, last_d;

  logic                     load;
  logic [N-1:0]             req;
  logic [N-1:0]             grant;
  logic                     grant_vld;
  logic [ADDRESS_WIDTH-1:0] gidx;

`ifdef STREAM_MULTIPLEXOR_LAST_EN
  logic o_last_q, o_last_d;
  logic lock_q, lock_d;
`endif

  assign load = ~o_valid_q | i_ready;

  // while locked only the owning channel may compete
  always_comb begin
    req = i_valid;
`ifdef STREAM_MULTIPLEXOR_LAST_EN
    if (lock_q)
      req = i_valid & (N'(1) << last_q);
`endif
  end

  round_robin_arbiter #(
    .N (N)
  ) u_arb (
    .i_request     (req),
    .i_last_grant  (last_q),
    .i_enable      (load & ~i_reset),
    .o_grant       (grant),
    .o_grant_valid (grant_vld)
  );

  // one-hot grant to channel index
  always_comb begin
    gidx = '0;
    for (int k = 0; k < N; k++)
      if (grant[k])
        gidx = ADDRESS_WIDTH'(k);
  end

  // output register next state: load, drain or hold
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_addr_d  = o_addr_q;
    last_d    = last_q;
`ifdef STREAM_MULTIPLEXOR_LAST_EN
    o_last_d  = o_last_q;
    lock_d    = lock_q;
`endif
    if (grant_vld) begin
      o_valid_d = 1'b1;
      o_data_d  = i_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      o_addr_d  = gidx;
      last_d    = gidx;
`ifdef STREAM_MULTIPLEXOR_LAST_EN
      o_last_d  = i_last[gidx];
      lock_d    = ~i_last[gidx];
`endif
    end else if (o_valid_q & i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // state registers; reset drops any pending beat
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_addr_q  <= '0;
      last_q    <= ADDRESS_WIDTH'(N - 1);
`ifdef STREAM_MULTIPLEXOR_LAST_EN
      o_last_q  <= 1'b0;
      lock_q    <= 1'b0;
`endif
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_addr_q  <= o_addr_d;
      last_q    <= last_d;
`ifdef STREAM_MULTIPLEXOR_LAST_EN
      o_last_q  <= o_last_d;
      lock_q    <= lock_d;
`endif
    end
  end

  assign o_ready   = grant;
  assign o_valid   = o_valid_q;
  assign o_data    = o_data_q;
  assign o_address = o_addr_q;
`ifdef STREAM_MULTIPLEXOR_LAST_EN
  assign o_last    = o_last_q;
`endif

endmodule

// File: tb/tb_stream_multiplexor.sv
// Directed self-checking bench for stream_multiplexor.
// Packet-lock scenario runs when STREAM_MULTIPLEXOR_LAST_EN is defined.
module tb_stream_multiplexor;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_valid;
  logic [31:0] i_data;
  logic [3:0]  o_ready;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [1:0]  o_address;
  logic        i_ready;
`ifdef STREAM_MULTIPLEXOR_LAST_EN
  logic [3:0]  i_last;
  logic        o_last;
`endif

  int checks = 0;
  int errors = 0;

  stream_multiplexor #(
    .ADDRESS_WIDTH (2),
    .DATA_WIDTH    (8)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .i_data    (i_data),
`ifdef STREAM_MULTIPLEXOR_LAST_EN
    .i_last    (i_last),
    .o_last    (o_last),
`endif
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_address (o_address),
    .i_ready   (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic step;
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    i_valid = 4'b0000;
    i_ready = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    i_valid = 4'b1111;
    i_ready = 1'b1;
    i_data  = 32'h13121110;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h00 ||
          o_address !== 2'd0) begin
        $display("FAIL reset_out: got v=%b d=%h a=%0d want 0 00 0",
                 o_valid, o_data, o_address);
        errors++;
      end
      checks++;
      if (o_ready !== 4'b0000) begin
        $display("FAIL reset_ready: got %b want 0000", o_ready);
        errors++;
      end
    end
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_ready !== 4'b0001) begin
      $display("FAIL reset_first_ready: got %b want 0001", o_ready);
      errors++;
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_address !== 2'd0 || o_data !== 8'h10) begin
      $display("FAIL reset_first_beat: got v=%b a=%0d d=%h want 1 0 10",
               o_valid, o_address, o_data);
      errors++;
    end
    i_valid = 4'b0000;
    step();
  endtask

  task automatic test_single;
    do_reset();
    i_data  = 32'h00A50000;
    i_valid = 4'b0100;
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 4'b0100) begin
      $display("FAIL single_ready: got %b want 0100", o_ready);
      errors++;
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_address !== 2'd2) begin
      $display("FAIL single_beat: got v=%b d=%h a=%0d want 1 a5 2",
               o_valid, o_data, o_address);
      errors++;
    end
    i_valid = 4'b0000;
    step();
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'hA5 || o_address !== 2'd2) begin
      $display("FAIL drain_hold: got v=%b d=%h a=%0d want 0 a5 2",
               o_valid, o_data, o_address);
      errors++;
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_a [6];
    logic [7:0] exp_d [6];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
    do_reset();
    i_data  = 32'h13121110;
    i_valid = 4'b1111;
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (o_valid !== 1'b1 || o_address !== exp_a[c] ||
          o_data !== exp_d[c]) begin
        $display("FAIL rr_beat%0d: got v=%b a=%0d d=%h want 1 %0d %h",
                 c, o_valid, o_address, o_data, exp_a[c], exp_d[c]);
        errors++;
      end
    end
    i_valid = 4'b0000;
    step();
  endtask

  task automatic test_backpressure;
    do_reset();
    i_data  = 32'hD3003CA0;
    i_valid = 4'b0010;
    i_ready = 1'b1;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C || o_address !== 2'd1) begin
      $display("FAIL bp_first: got v=%b d=%h a=%0d want 1 3c 1",
               o_valid, o_data, o_address);
      errors++;
    end
    i_ready = 1'b0;
    i_valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (o_ready !== 4'b0000) begin
        $display("FAIL bp_ready%0d: got %b want 0000", c, o_ready);
        errors++;
      end
      step();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h3C || o_address !== 2'd1) begin
        $display("FAIL bp_stall%0d: got v=%b d=%h a=%0d want 1 3c 1",
                 c, o_valid, o_data, o_address);
        errors++;
      end
    end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 4'b1000) begin
      $display("FAIL bp_resume_ready: got %b want 1000", o_ready);
      errors++;
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_address !== 2'd3 || o_data !== 8'hD3) begin
      $display("FAIL bp_ch3: got v=%b a=%0d d=%h want 1 3 d3",
               o_valid, o_address, o_data);
      errors++;
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_address !== 2'd0 || o_data !== 8'hA0) begin
      $display("FAIL bp_ch0: got v=%b a=%0d d=%h want 1 0 a0",
               o_valid, o_address, o_data);
      errors++;
    end
    i_valid = 4'b0000;
    step();
  endtask

  task automatic test_idle_pointer;
    do_reset();
    i_data  = 32'h44332211;
    i_valid = 4'b0010;
    i_ready = 1'b1;
    step();
    i_valid = 4'b0000;
    for (int c = 0; c < 4; c++)
      step();
    i_valid = 4'b0101;
    #1;
    checks++;
    if (o_ready !== 4'b0100) begin
      $display("FAIL idle_ptr_ready: got %b want 0100", o_ready);
      errors++;
    end
    step();
    checks++;
    if (o_address !== 2'd2 || o_data !== 8'h33) begin
      $display("FAIL idle_ptr_beat: got a=%0d d=%h want 2 33",
               o_address, o_data);
      errors++;
    end
    i_valid = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid;
    do_reset();
    i_data  = 32'h00770000;
    i_valid = 4'b0100;
    i_ready = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h77) begin
      $display("FAIL mid_pending: got v=%b d=%h want 1 77", o_valid, o_data);
      errors++;
    end
    i_valid = 4'b0000;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_ready = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h00) begin
      $display("FAIL mid_reset: got v=%b d=%h want 0 00", o_valid, o_data);
      errors++;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (o_valid !== 1'b0 || o_data === 8'h77) begin
        $display("FAIL mid_after%0d: got v=%b d=%h want 0 not-77",
                 c, o_valid, o_data);
        errors++;
      end
    end
  endtask

`ifdef STREAM_MULTIPLEXOR_LAST_EN
  task automatic test_packet_lock;
    logic [3:0] lasts [3];
    logic [7:0] dats [3];
    lasts = '{4'b0000, 4'b0000, 4'b0001};
    dats  = '{8'hB0, 8'hB1, 8'hB2};
    do_reset();
    i_ready = 1'b1;
    i_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      i_data = {16'h0, 8'hC1, dats[c]};
      i_last = lasts[c];
      #1;
      checks++;
      if (o_ready !== 4'b0001) begin
        $display("FAIL lock_ready%0d: got %b want 0001", c, o_ready);
        errors++;
      end
      step();
      checks++;
      if (o_address !== 2'd0 || o_data !== dats[c] ||
          o_last !== lasts[c][0]) begin
        $display("FAIL lock_beat%0d: got a=%0d d=%h l=%b want 0 %h %b",
                 c, o_address, o_data, o_last, dats[c], lasts[c][0]);
        errors++;
      end
    end
    i_last = 4'b0010;
    step();
    checks++;
    if (o_address !== 2'd1 || o_data !== 8'hC1) begin
      $display("FAIL lock_release: got a=%0d d=%h want 1 c1",
               o_address, o_data);
      errors++;
    end
    i_valid = 4'b0000;
    i_last  = 4'b0000;
    step();
  endtask
`endif

  initial begin
    i_reset = 1'b1;
    i_valid = 4'b0000;
    i_data  = '0;
    i_ready = 1'b1;
`ifdef STREAM_MULTIPLEXOR_LAST_EN
    i_last  = 4'b1111;
`endif
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_idle_pointer();
    test_reset_mid();
`ifdef STREAM_MULTIPLEXOR_LAST_EN
    test_packet_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
